// File: rtl/ulpi_rxcmd_monitor_pkg.sv
// Shared ULPI RXCMD field layout, line/VBUS/event encodings, bus-state encodings and default tick constants.
package ulpi_rxcmd_monitor_pkg;

  localparam int unsigned DEF_RESET_TICKS   = 180;     // 3.0 us SE0 at 60 MHz
  localparam int unsigned DEF_SUSPEND_TICKS = 180000;  // 3.0 ms idle J at 60 MHz
  localparam int unsigned DEF_TMR_W         = 18;
  localparam int unsigned ERR_W             = 16;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [1:0] {
    VB_SESS_END  = 2'b00,
    VB_SESS_VLD  = 2'b01,
    VB_A_VLD     = 2'b10,
    VB_VALID     = 2'b11
  } vbus_state_t;

  typedef enum logic [1:0] {
    EV_NONE      = 2'b00,
    EV_ACTIVE    = 2'b01,
    EV_HOST_DISC = 2'b10,
    EV_ERROR     = 2'b11
  } rx_event_t;

  typedef enum logic [2:0] {
    ST_DETACHED   = 3'd0,
    ST_ACTIVE     = 3'd1,
    ST_SE0_TIMING = 3'd2,
    ST_IN_RESET   = 3'd3,
    ST_SUSPEND    = 3'd4
  } bus_state_t;

  // RXCMD[6:0] bit positions: [6] id_gnd, [5:4] rx_event, [3:2] vbus, [1:0] line
  typedef struct packed {
    logic        id_gnd;
    rx_event_t   rx_event;
    vbus_state_t vbus;
    line_state_t line;
  } rxcmd_t;

endpackage

// File: rtl/ulpi_rxcmd_monitor_line_timer.sv
// usb_line_timer: saturating cycle counter with clear/enable and a terminal-count compare.
module usb_line_timer #(
  parameter int unsigned W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         hit_c
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

  assign hit_c = (count == term);

endmodule

// File: rtl/ulpi_rxcmd_monitor.sv
// ULPI RXCMD decoder and USB device bus-state monitor (detach, bus reset, suspend, resume).
// Optional RX error counter built when RXCMD_ERRCNT_EN is defined.
module ulpi_rxcmd_monitor
  import ulpi_rxcmd_monitor_pkg::*;
#(
  parameter int unsigned RESET_TICKS   = DEF_RESET_TICKS,
  parameter int unsigned SUSPEND_TICKS = DEF_SUSPEND_TICKS,
  parameter int unsigned TMR_W         = DEF_TMR_W
) (
  input  logic             CLK_60M,
  input  logic             RST_USB,
  input  logic [7:0]       RXCMD,
  input  logic             RXCMD_VALID,
  output logic [1:0]       LINE_STATE,
  output logic [1:0]       VBUS_STATE,
  output logic             RX_ACTIVE,
  output logic             RX_ERROR,
  output logic             HOST_DISC,
  output logic             ID_GND,
  output logic             ATTACHED,
  output logic             BUS_RESET,
  output logic             RESET_ACTIVE,
  output logic             SUSPENDED,
  output logic             RESUME,
  output logic             LINE_CHANGE,
  output logic [ERR_W-1:0] ERR_CNT
);

  rxcmd_t     cmd;
  bus_state_t state;
  bus_state_t nxt_state;
  logic       bus_reset_c;
  logic       resume_c;
  logic       run_c;
  logic       hit_c;
  logic [TMR_W-1:0] term;
  logic       unused_alt_int;

  assign cmd            = rxcmd_t'(RXCMD[6:0]);
  assign unused_alt_int = RXCMD[7];

  // Field capture; LINE_CHANGE compares against the value being replaced
  always_ff @(posedge CLK_60M) begin
    if (RST_USB) begin
      LINE_STATE  <= 2'b00;
      VBUS_STATE  <= 2'b00;
      RX_ACTIVE   <= 1'b0;
      RX_ERROR    <= 1'b0;
      HOST_DISC   <= 1'b0;
      ID_GND      <= 1'b0;
      LINE_CHANGE <= 1'b0;
    end else begin
      LINE_CHANGE <= RXCMD_VALID && (cmd.line != LINE_STATE);
      if (RXCMD_VALID) begin
        LINE_STATE <= cmd.line;
        VBUS_STATE <= cmd.vbus;
        RX_ACTIVE  <= (cmd.rx_event == EV_ACTIVE) || (cmd.rx_event == EV_ERROR);
        RX_ERROR   <= (cmd.rx_event == EV_ERROR);
        HOST_DISC  <= (cmd.rx_event == EV_HOST_DISC);
        ID_GND     <= cmd.id_gnd;
      end
    end
  end

  assign term = (state == ST_SE0_TIMING) ? TMR_W'(RESET_TICKS - 1) : TMR_W'(SUSPEND_TICKS - 1);

  // Next-state from registered fields: detach first, then SE0, then per-state rules
  always_comb begin
    nxt_state   = state;
    bus_reset_c = 1'b0;
    resume_c    = 1'b0;
    run_c       = 1'b0;
    if (VBUS_STATE != VB_VALID) begin
      nxt_state = ST_DETACHED;
    end else if (state == ST_DETACHED) begin
      nxt_state = ST_ACTIVE;
    end else if ((LINE_STATE == LS_SE0) && ((state == ST_ACTIVE) || (state == ST_SUSPEND))) begin
      nxt_state = ST_SE0_TIMING;
    end else begin
      case (state)
        ST_ACTIVE: begin
          run_c = (LINE_STATE == LS_J) && !RX_ACTIVE;
          if (run_c && hit_c) nxt_state = ST_SUSPEND;
        end
        ST_SE0_TIMING: begin
          if (LINE_STATE != LS_SE0) begin
            nxt_state = ST_ACTIVE;
          end else begin
            run_c = 1'b1;
            if (hit_c) begin
              nxt_state   = ST_IN_RESET;
              bus_reset_c = 1'b1;
            end
          end
        end
        ST_IN_RESET: begin
          if (LINE_STATE != LS_SE0) nxt_state = ST_ACTIVE;
        end
        ST_SUSPEND: begin
          if (LINE_STATE == LS_K) begin
            nxt_state = ST_ACTIVE;
            resume_c  = 1'b1;
          end
        end
        default: nxt_state = ST_DETACHED;
      endcase
    end
  end

  always_ff @(posedge CLK_60M) begin
    if (RST_USB) begin
      state        <= ST_DETACHED;
      ATTACHED     <= 1'b0;
      BUS_RESET    <= 1'b0;
      RESET_ACTIVE <= 1'b0;
      SUSPENDED    <= 1'b0;
      RESUME       <= 1'b0;
    end else begin
      state        <= nxt_state;
      ATTACHED     <= (nxt_state != ST_DETACHED);
      BUS_RESET    <= bus_reset_c;
      RESET_ACTIVE <= (nxt_state == ST_IN_RESET);
      SUSPENDED    <= (nxt_state == ST_SUSPEND);
      RESUME       <= resume_c;
    end
  end

  // Idle/SE0 duration; restarts on any state change, line change or loss of the timed condition
  usb_line_timer #(.W(TMR_W)) u_timer (
    .clk   (CLK_60M),
    .rst   (RST_USB),
    .clr   ((nxt_state != state) || LINE_CHANGE || !run_c),
    .en    (run_c),
    .term  (term),
    .hit_c (hit_c)
  );

`ifdef RXCMD_ERRCNT_EN
  logic rx_error_d;

  always_ff @(posedge CLK_60M) begin
    if (RST_USB) begin
      rx_error_d <= 1'b0;
      ERR_CNT    <= '0;
    end else begin
      rx_error_d <= RX_ERROR;
      if (BUS_RESET) begin
        ERR_CNT <= '0;
      end else if (RX_ERROR && !rx_error_d && (ERR_CNT != '1)) begin
        ERR_CNT <= ERR_CNT + ERR_W'(1);
      end
    end
  end
`else
  assign ERR_CNT = '0;
`endif

endmodule

// File: doc/ulpi_rxcmd_monitor.md
Name: ulpi_rxcmd_monitor

Overview:
- Sits directly downstream of the ULPI PHY interface block and consumes its RXCMD byte stream.
- Decodes each RXCMD into LineState, VbusState, RxEvent and ID fields.
- Times bus conditions to produce USB device bus-state events (detach, bus reset, suspend, resume) for the device core and debug LEDs.
- All timing runs in the 60 MHz ULPI clock domain.

Parameters:
- RESET_TICKS, 180: SE0 duration in cycles (3.0 us at 60 MHz) that declares a bus reset.
- SUSPEND_TICKS, 180000: idle-J duration in cycles (3.0 ms) that declares suspend.
- TMR_W, 18: timer width; must hold SUSPEND_TICKS.

Ports:
- CLK_60M  in  1  ULPI PHY clock; the block's only clock.
- RST_USB  in  1  synchronous, active-high reset.
- RXCMD  in  8  last RXCMD byte from the ULPI block.
- RXCMD_VALID  in  1  one-cycle strobe; RXCMD holds a new byte.
- LINE_STATE  out  2  registered LineState (RXCMD[1:0]).
- VBUS_STATE  out  2  registered VbusState (RXCMD[3:2]).
- RX_ACTIVE  out  1  RxEvent==01 or 11.
- RX_ERROR  out  1  RxEvent==11.
- HOST_DISC  out  1  RxEvent==10.
- ID_GND  out  1  RXCMD[6].
- ATTACHED  out  1  level; FSM not in DETACHED.
- BUS_RESET  out  1  one-cycle pulse on entry to IN_RESET.
- RESET_ACTIVE  out  1  level while in IN_RESET.
- SUSPENDED  out  1  level while in SUSPEND.
- RESUME  out  1  one-cycle pulse on SUSPEND -> ACTIVE via K.
- LINE_CHANGE  out  1  one-cycle pulse when a new RXCMD changes LineState.
- ERR_CNT  out  16  RxError event count; see Optional Feature.

Behaviour:
- Interface: one clock, CLK_60M. Reset RST_USB is synchronous and active-high.
- Reset values: all outputs 0; LINE_STATE=00; VBUS_STATE=00; FSM=DETACHED; timer=0.
- Field capture: on RXCMD_VALID, all decoded fields register on the same edge, so outputs follow one cycle after the strobe. Fields hold between strobes. RXCMD is ignored when RXCMD_VALID=0.
- LINE_CHANGE: pulses in the cycle after capture when the new LineState differs from the held one.
- Line encodings: SE0=00, J=01, K=10, SE1=11.
- Timer: saturating TMR_W-bit counter, incremented every cycle while the FSM condition holds. It clears on every FSM transition and on every LINE_CHANGE.
- FSM evaluation: transitions use the registered fields. Priority order is DETACHED check, then SE0, then the state-specific rules.
  - Any state -> DETACHED: VBUS_STATE != 11.
  - DETACHED -> ACTIVE: VBUS_STATE==11.
  - ACTIVE -> SE0_TIMING: LINE_STATE==SE0.
  - ACTIVE -> SUSPEND: LINE_STATE==J and !RX_ACTIVE and timer==SUSPEND_TICKS-1. Any non-J LineState or RX_ACTIVE holds the timer at 0.
  - SE0_TIMING -> IN_RESET: timer==RESET_TICKS-1; BUS_RESET pulses.
  - SE0_TIMING -> ACTIVE: LineState leaves SE0 before threshold (EOP or glitch); no event.
  - IN_RESET -> ACTIVE: LineState != SE0. RESET_ACTIVE deasserts the same cycle.
  - SUSPEND -> ACTIVE: LINE_STATE==K; RESUME pulses.
  - SUSPEND -> SE0_TIMING: LINE_STATE==SE0, i.e. reset from suspend; no RESUME.
  - SE1 in any attached state: treated as non-idle; the timer holds at 0.
- Simultaneous events: when RXCMD_VALID and a timer threshold coincide, the threshold transition fires using the old registered fields. The new fields are evaluated in the next cycle.
- Reset mid-operation: RST_USB asserted in any state returns everything to reset values on the next edge, and no pulses are emitted on that edge.

Optional Feature:
- Macro: RXCMD_ERRCNT_EN.
- Defined: ERR_CNT increments by 1 on each rising edge of RX_ERROR, saturating at 16'hFFFF. It clears on RST_USB and on BUS_RESET.
- Undefined: no counter logic is built and ERR_CNT is tied to 16'd0.

Decomposition:
- Shared ulpi defines include holds:
  - RXCMD bit-field positions;
  - LineState, VbusState and RxEvent encodings;
  - FSM state encodings (3-bit: DETACHED, ACTIVE, SE0_TIMING, IN_RESET, SUSPEND);
  - default tick constants.
- One sub-module, usb_line_timer, contains the saturating counter with clear, enable and a terminal-count compare. It is instantiated once.

Test Plan:
- Reset, then RXCMD=8'h0D (VBUS=11, J) strobed -> next cycle LINE_STATE=01, VBUS_STATE=11; following cycle ATTACHED=1, all pulses 0.
- Attached, RXCMD=8'h0C (SE0) held 180 cycles -> BUS_RESET single pulse at cycle 180, RESET_ACTIVE=1; then 8'h0D -> RESET_ACTIVE=0, state ACTIVE.
- Attached, SE0 held 100 cycles then J -> no BUS_RESET, LINE_CHANGE pulsed twice, timer cleared.
- J idle 180000 cycles with no RxActive -> SUSPENDED=1. RXCMD=8'h0E (K) -> RESUME one pulse, SUSPENDED=0.
- While SUSPENDED, RXCMD=8'h00 (VBUS=00) -> ATTACHED=0, SUSPENDED=0; J with VBUS=11 re-attaches.
- With RXCMD_ERRCNT_EN: three RXCMD=8'h3D strobes separated by 8'h0D -> ERR_CNT=3; bus reset -> ERR_CNT=0. Without the macro, ERR_CNT stays 0.
